jk_excite_ctrl: RTL and testbench
=================================

JK_EXCITE_CTRL -- requirements
Module: jk_excite_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, giving the width of the driven JK flip-flop bank.
REQ-002 SHALL have parameter PREFER_TOGGLE, default 0: 1 encodes every bit change as J=K=1; 0 uses set/reset excitation.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tgt_data  input  W  requested next value for the external bank.
REQ-006 tgt_valid  input  1  tgt_data is valid.
REQ-007 tgt_ready  output  1  controller can accept a request.
REQ-008 j  output  W  per-bit J command to the external bank.
REQ-009 k  output  W  per-bit K command to the external bank.
REQ-010 q_fb  input  W  Q outputs of the external bank, fed back.
REQ-011 done  output  1  one-cycle pulse when a request completes.
REQ-012 err  output  1  one-cycle pulse, coincident with done, when q_fb differed from the target.
REQ-013 shadow  output  W  controller's tracked bank value.
REQ-014 chg_cnt  output  16  running count of bit changes commanded.

Function
REQ-015 SHALL implement the FSM states IDLE, DRIVE, CHECK and REPORT.
REQ-016 IDLE: tgt_ready=1; tgt_valid=1 registers tgt_data into tgt_reg and moves the FSM to DRIVE; otherwise the FSM stays in IDLE.
REQ-017 DRIVE (exactly one cycle): j/k carry the excitation for shadow->tgt_reg; next state is CHECK.
REQ-018 Excitation per bit with PREFER_TOGGLE=0: 0->0 gives J0 K0; 0->1 gives J1 K0; 1->0 gives J0 K1; 1->1 gives J0 K0.
REQ-019 Excitation per bit with PREFER_TOGGLE=1: a changed bit gives J1 K1; an unchanged bit gives J0 K0.
REQ-020 In every state except DRIVE, j and k SHALL be all-zero, so the bank holds its value.
REQ-021 CHECK (one cycle): compare q_fb against tgt_reg, load shadow from q_fb, then go to REPORT.
REQ-022 REPORT (one cycle): assert done; assert err if the CHECK comparison mismatched; then return to IDLE.
REQ-023 Latency: for a request accepted at edge N, j/k drive during cycle N+1, and done is high during cycle N+3.
REQ-024 Back-to-back requests: the next request is accepted no earlier than the edge that leaves REPORT, giving a throughput of one request per 4 cycles.
REQ-025 tgt_valid and tgt_data changes outside IDLE SHALL be ignored; no queuing.
REQ-026 When tgt_data equals shadow, DRIVE SHALL output all-zero j/k, and the request still completes with done.
REQ-027 chg_cnt SHALL add popcount(shadow XOR tgt_reg) on the DRIVE cycle, wrapping modulo 2^16.
REQ-028 chg_cnt SHALL be unchanged when a request is an equal-value request.
REQ-029 All outputs SHALL be registered, and no combinational path SHALL run from inputs to outputs.

Reset
REQ-030 rst high SHALL force, at any time and including mid-request, the following values:
  - state=IDLE
  - tgt_ready=1
  - j=k=0
  - done=err=0
  - shadow=0 (matches the bank's power-up Q=0)
  - tgt_reg=0
  - chg_cnt=0
REQ-031 A request in flight at reset SHALL be abandoned with no done pulse.
REQ-032 The first request after rst deasserts SHALL be accepted on the first rising edge at which tgt_valid=1.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration and the JK command encodings HOLD, SET, RESET and TOGGLE.
REQ-034 SHALL have one sub-module, jk_excite_bit: a purely combinational per-bit encoder from (cur, nxt, prefer_toggle) to (j, k), instantiated W times.

Verification
REQ-035 After reset, request 8'hA5 with PREFER_TOGGLE=0 and a model bank -> the DRIVE cycle shows j=A5, k=00; done is high in cycle N+3; err=0; shadow=A5; chg_cnt=4.
REQ-036 From shadow=A5, request 8'h5A with PREFER_TOGGLE=1 -> j=k=FF; shadow=5A; chg_cnt=12.
REQ-037 From shadow=5A, request 8'h5A -> j=k=00 in DRIVE; done=1; err=0; chg_cnt unchanged.
REQ-038 Model bank forces bit0 stuck at 0, request 8'h01 -> err=1 together with done; shadow=00.
REQ-039 Assert rst during CHECK -> no done; shadow=0; tgt_ready=1 in the next cycle.
REQ-040 Hold tgt_valid=1 continuously with changing data -> requests are accepted only in IDLE, every 4 cycles, and each done matches the accepted value.

Source files
------------

// File: rtl/jk_excite_ctrl_pkg.sv
// Shared definitions for the JK excitation controller: FSM states,
// per-bit JK command encodings and the change-counter width.
package jk_excite_ctrl_pkg;

    // Request sequencing: accept, drive the bank, read it back, report.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        CHECK  = 2'b10,
        REPORT = 2'b11
    } state_t;

    // JK command per bit, packed as {J, K}.
    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_cmd_t;

    // Width of the running bit-change counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/jk_excite_ctrl_bit.sv
// Combinational per-bit JK excitation encoder: given the current and the
// wanted next value of one flip-flop, produce the J/K pair that moves it.
module jk_excite_bit
    import jk_excite_ctrl_pkg::*;
(
    input  logic cur,
    input  logic nxt,
    input  logic prefer_toggle,
    output logic j,
    output logic k
);

    jk_cmd_t cmd;

    // Pick the command: hold unchanged bits, otherwise toggle or set/reset.
    always_comb begin
        cmd = HOLD;
        if (cur != nxt) begin
            if (prefer_toggle) begin
                cmd = TOGGLE;
            end else if (nxt) begin
                cmd = SET;
            end else begin
                cmd = RESET;
            end
        end
    end

    assign {j, k} = cmd;

endmodule

// File: rtl/jk_excite_ctrl.sv
// JK excitation controller: accepts a target value for an external JK
// flip-flop bank, drives the J/K commands for one cycle, reads the bank
// back, and reports completion (and any mismatch) with a one-cycle pulse.
// Every output is a register; the next-state logic only feeds flops.
module jk_excite_ctrl
    import jk_excite_ctrl_pkg::*;
#(
    parameter int W             = 8,
    parameter int PREFER_TOGGLE = 0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [W-1:0]     j,
    output logic [W-1:0]     k,
    input  logic [W-1:0]     q_fb,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     shadow,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic PT = (PREFER_TOGGLE != 0);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     tgt_reg;
    logic [W-1:0]     tgt_reg_nxt;
    logic [W-1:0]     shadow_nxt;
    logic [W-1:0]     j_nxt;
    logic [W-1:0]     k_nxt;
    logic [W-1:0]     exc_j;
    logic [W-1:0]     exc_k;
    logic             ready_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Number of set bits, widened to the counter width.
    function automatic logic [CNT_W-1:0] popcount(input logic [W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // The excitation is computed from the incoming request so it can be
    // registered on the accept edge and appear during the DRIVE cycle;
    // this equals the shadow->tgt_reg excitation since both load together.
    for (genvar i = 0; i < W; i++) begin : g_bit
        jk_excite_bit u_bit (
            .cur           (shadow[i]),
            .nxt           (tgt_data[i]),
            .prefer_toggle (PT),
            .j             (exc_j[i]),
            .k             (exc_k[i])
        );
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nxt   = state;
        tgt_reg_nxt = tgt_reg;
        shadow_nxt  = shadow;
        cnt_nxt     = chg_cnt;
        ready_nxt   = 1'b0;
        j_nxt       = '0;
        k_nxt       = '0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (tgt_valid) begin
                    tgt_reg_nxt = tgt_data;
                    j_nxt       = exc_j;
                    k_nxt       = exc_k;
                    ready_nxt   = 1'b0;
                    state_nxt   = DRIVE;
                end
            end
            DRIVE: begin
                // Equal-value requests add zero, leaving the count untouched.
                cnt_nxt   = chg_cnt + popcount(shadow ^ tgt_reg);
                state_nxt = CHECK;
            end
            CHECK: begin
                // The bank has had one edge to apply j/k; trust what it reports.
                shadow_nxt = q_fb;
                err_nxt    = (q_fb != tgt_reg);
                done_nxt   = 1'b1;
                state_nxt  = REPORT;
            end
            REPORT: begin
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tgt_reg   <= '0;
            shadow    <= '0;
            chg_cnt   <= '0;
            tgt_ready <= 1'b1;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt_reg   <= tgt_reg_nxt;
            shadow    <= shadow_nxt;
            chg_cnt   <= cnt_nxt;
            tgt_ready <= ready_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench for jk_excite_ctrl: two instances (set/reset and toggle excitation)
// each drive their own model JK bank; a transaction-level reference model
// predicts every output each cycle, and directed requests pin literal values.
module tb_jk_excite_ctrl;

    localparam int W = 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic [W-1:0]  tgt_data  = '0;
    logic          tgt_valid = 1'b0;
    logic [W-1:0]  stuck     = '0;

    logic          rdy0, rdy1, done0, done1, err0, err1;
    logic [W-1:0]  j0, k0, j1, k1, sh0, sh1;
    logic [W-1:0]  bank0, bank1, qfb0, qfb1;
    logic [15:0]   cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jk_excite_ctrl #(.W(W), .PREFER_TOGGLE(0)) dut0 (
        .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
        .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(qfb0), .done(done0),
        .err(err0), .shadow(sh0), .chg_cnt(cnt0)
    );

    jk_excite_ctrl #(.W(W), .PREFER_TOGGLE(1)) dut1 (
        .clk(clk), .rst(rst), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
        .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(qfb1), .done(done1),
        .err(err1), .shadow(sh1), .chg_cnt(cnt1)
    );

    // JK characteristic equation: Q+ = J&~Q | ~K&Q
    function automatic logic [W-1:0] jk_next(input logic [W-1:0] q,
                                             input logic [W-1:0] jj,
                                             input logic [W-1:0] kk);
        return (jj & ~q) | (~kk & q);
    endfunction

    // Model banks (power up / reset to zero); stuck bits read back as 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bank0 <= '0;
            bank1 <= '0;
        end else begin
            bank0 <= jk_next(bank0, j0, k0);
            bank1 <= jk_next(bank1, j1, k1);
        end
    end
    assign qfb0 = bank0 & ~stuck;
    assign qfb1 = bank1 & ~stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs for the cycle following each edge,
    // derived from the number of edges since a request was accepted.
    int            age     = 0;
    bit            chk_en  = 1'b0;
    logic          m_ready = 1'b1;
    logic          m_done  = 1'b0;
    logic [W-1:0]  m_tgt   = '0;
    logic [W-1:0]  m_j[2];
    logic [W-1:0]  m_k[2];
    logic [W-1:0]  m_sh[2];
    logic          m_err[2];
    logic [15:0]   m_cnt[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age     = 0;
            chk_en  = 1'b1;
            m_ready = 1'b1;
            m_done  = 1'b0;
            m_tgt   = '0;
            for (int i = 0; i < 2; i++) begin
                m_j[i] = '0; m_k[i] = '0; m_sh[i] = '0; m_err[i] = 1'b0; m_cnt[i] = '0;
            end
        end else begin
            m_done = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_j[i] = '0; m_k[i] = '0; m_err[i] = 1'b0;
            end
            if (age == 0) begin
                if (tgt_valid) begin
                    m_tgt   = tgt_data;
                    m_j[0]  = ~m_sh[0] & m_tgt;
                    m_k[0]  = m_sh[0] & ~m_tgt;
                    m_j[1]  = m_sh[1] ^ m_tgt;
                    m_k[1]  = m_sh[1] ^ m_tgt;
                    m_ready = 1'b0;
                    age     = 1;
                end
            end else if (age == 1) begin
                for (int i = 0; i < 2; i++)
                    m_cnt[i] = m_cnt[i] + 16'($countones(m_sh[i] ^ m_tgt));
                age = 2;
            end else if (age == 2) begin
                m_err[0] = (qfb0 != m_tgt);
                m_err[1] = (qfb1 != m_tgt);
                m_sh[0]  = qfb0;
                m_sh[1]  = qfb1;
                m_done   = 1'b1;
                age      = 3;
            end else begin
                m_ready = 1'b1;
                age     = 0;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready0", rdy0, m_ready);
            check("ready1", rdy1, m_ready);
            check("j0", j0, m_j[0]);
            check("k0", k0, m_k[0]);
            check("j1", j1, m_j[1]);
            check("k1", k1, m_k[1]);
            check("done0", done0, m_done);
            check("done1", done1, m_done);
            check("err0", err0, m_err[0]);
            check("err1", err1, m_err[1]);
            check("shadow0", sh0, m_sh[0]);
            check("shadow1", sh1, m_sh[1]);
            check("cnt0", cnt0, m_cnt[0]);
            check("cnt1", cnt1, m_cnt[1]);
        end
    end

    // One request from IDLE with hand-computed expectations for DRIVE and REPORT.
    task automatic req_lit(input logic [W-1:0] d,
                           input logic [W-1:0] ej0, input logic [W-1:0] ek0,
                           input logic [W-1:0] ej1, input logic [W-1:0] ek1,
                           input logic eerr, input logic [W-1:0] esh,
                           input logic [15:0] ecnt);
        tgt_valid = 1'b1;
        tgt_data  = d;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        tgt_data  = W'($urandom);
        @(negedge clk);
        check("lit_drive_j0", j0, ej0);
        check("lit_drive_k0", k0, ek0);
        check("lit_drive_j1", j1, ej1);
        check("lit_drive_k1", k1, ek1);
        @(negedge clk);
        @(negedge clk);
        check("lit_done0", done0, 1'b1);
        check("lit_done1", done1, 1'b1);
        check("lit_err0", err0, eerr);
        check("lit_err1", err1, eerr);
        check("lit_shadow0", sh0, esh);
        check("lit_shadow1", sh1, esh);
        check("lit_cnt0", cnt0, ecnt);
        check("lit_cnt1", cnt1, ecnt);
        @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy0, 1'b1);
        check("rst_jk", {j0, k0, j1, k1}, 32'h0);
        check("rst_done", done0, 1'b0);
        check("rst_shadow", sh0, 8'h00);
        check("rst_cnt", cnt0, 16'h0);
        rst = 1'b0;

        req_lit(8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0, 8'hA5, 16'd4);
        req_lit(8'h5A, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 1'b0, 8'h5A, 16'd12);
        req_lit(8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 16'd12);
        stuck = 8'h01;
        req_lit(8'h01, 8'h01, 8'h5A, 8'h5B, 8'h5B, 1'b1, 8'h00, 16'd17);
        stuck = 8'h00;

        // Reset while the request sits in CHECK: abandoned, no done.
        tgt_valid = 1'b1;
        tgt_data  = 8'h3C;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midrst_done0", done0, 1'b0);
        check("midrst_shadow0", sh0, 8'h00);
        check("midrst_shadow1", sh1, 8'h00);
        check("midrst_ready0", rdy0, 1'b1);
        check("midrst_cnt0", cnt0, 16'h0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_nodone", {done0, done1}, 2'b00);
        end

        // Valid held high with data changing every cycle.
        repeat (160) begin
            tgt_valid = 1'b1;
            tgt_data  = W'($urandom);
            @(negedge clk);
        end

        // Random valid, occasional stuck bits and occasional resets.
        repeat (400) begin
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_data  = W'($urandom);
            stuck     = ($urandom_range(0, 9) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 79) == 0) begin
                #2 rst = 1'b1;
            end
            @(negedge clk);
            rst = 1'b0;
        end

        tgt_valid = 1'b0;
        stuck     = '0;
        repeat (6) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
